// File: rtl/autosa_bdma_rd_client.sv
// -----------------------------------------------------------------------------
// autosa_bdma_rd_client
//   MCIF-side read client for the BDMA engine.
//   - Gates BDMA read requests against a credit budget. The budget is the
//     number of entries in the BDMA latency FIFO.
//   - Registers accepted requests toward the MCIF.
//   - Retimes MCIF read-response beats into BDMA through a 2-entry FIFO.
//   - Returns one credit on each bdma_rd_cdt_pop pulse.
//
// Ports
//   autosa_core_clk / autosa_core_rst  clock, synchronous active-high reset
//   bdma_rd_req_*   BDMA request in   (pd[63:0] addr, pd[78:64] beats-1)
//   mcif_rd_req_*   registered request out to the MCIF
//   mcif_rd_rsp_*   MCIF response beats in (ready is registered)
//   bdma_rd_rsp_*   response beats out to BDMA
//   bdma_rd_cdt_pop one latency-FIFO entry freed (+1 credit)
//   cdt_free        current free credits
//   rd_idle         no held request, response FIFO empty, all credits free
//   err_oversize    sticky: a request needed more than CDT_MAX beats
//   err_cdt_ovf     sticky: credit pop received while credits were full
//
// Optional build macro: AUTOSA_BDMA_RDCLT_PERF_EN
//   When defined, the module gains these ports:
//   perf_clr            synchronous clear of the perf counters
//   perf_cdt_stall_cnt  cycles a request waited on a credit shortfall
//   perf_cdt_hiwat      peak credits in use
// -----------------------------------------------------------------------------
module autosa_bdma_rd_client #(
  parameter int REQ_W   = 79,
  parameter int RSP_W   = 514,
  parameter int CDT_MAX = 256,
  parameter int CW      = 9
) (
  input  logic             autosa_core_clk,
  input  logic             autosa_core_rst,
  input  logic             bdma_rd_req_valid,
  output logic             bdma_rd_req_ready,
  input  logic [REQ_W-1:0] bdma_rd_req_pd,
  output logic             mcif_rd_req_valid,
  input  logic             mcif_rd_req_ready,
  output logic [REQ_W-1:0] mcif_rd_req_pd,
  input  logic             mcif_rd_rsp_valid,
  output logic             mcif_rd_rsp_ready,
  input  logic [RSP_W-1:0] mcif_rd_rsp_pd,
  output logic             bdma_rd_rsp_valid,
  input  logic             bdma_rd_rsp_ready,
  output logic [RSP_W-1:0] bdma_rd_rsp_pd,
  input  logic             bdma_rd_cdt_pop,
  output logic [CW-1:0]    cdt_free,
  output logic             rd_idle,
  output logic             err_oversize,
  output logic             err_cdt_ovf
`ifdef AUTOSA_BDMA_RDCLT_PERF_EN
  ,
  input  logic             perf_clr,
  output logic [31:0]      perf_cdt_stall_cnt,
  output logic [CW-1:0]    perf_cdt_hiwat
`endif
);

  localparam logic [15:0]   LP_MAX16 = 16'(CDT_MAX);
  localparam logic [CW-1:0] LP_MAXCW = CW'(CDT_MAX);

  // ---------------------------------------------------------------- state
  logic             r_req_valid;
  logic [REQ_W-1:0] r_req_pd;
  logic [CW-1:0]    r_cdt_free;
  logic             r_idle;
  logic             r_err_oversize;
  logic             r_err_cdt_ovf;
  logic             r_rsp_ready;
  logic [1:0]       r_count;
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [RSP_W-1:0] r_mem [2];

  // ------------------------------------------------------- request gating
  logic [15:0]   w_need;
  logic          w_oversize;
  logic          w_fits;
  logic          w_slot;
  logic          w_req_ready;
  logic          w_accept;
  logic          w_reserve;
  logic          w_pop_ok;
  logic          w_cdt_ovf;
  logic [CW-1:0] w_cdt_nxt;
  logic          w_req_valid_nxt;

  assign w_need      = {1'b0, bdma_rd_req_pd[78:64]} + 16'd1;
  assign w_oversize  = w_need > LP_MAX16;
  // The credit check uses only the registered count. A pop in the same
  // cycle becomes usable one cycle later.
  assign w_fits      = w_need <= 16'(r_cdt_free);
  assign w_slot      = !r_req_valid || mcif_rd_req_ready;
  // Oversize requests are always accepted so that they can be dropped.
  assign w_req_ready = w_slot && (w_fits || w_oversize);
  assign w_accept    = bdma_rd_req_valid && w_req_ready;
  assign w_reserve   = w_accept && !w_oversize;

  // A pop while already full is ignored unless a reservation in the same
  // cycle makes room for it.
  assign w_pop_ok  = bdma_rd_cdt_pop && (w_reserve || (r_cdt_free != LP_MAXCW));
  assign w_cdt_ovf = bdma_rd_cdt_pop && !w_reserve && (r_cdt_free == LP_MAXCW);

  always_comb begin
    w_cdt_nxt = r_cdt_free;
    // A reservation needs need <= r_cdt_free <= CDT_MAX, so need fits in CW bits.
    if (w_reserve) w_cdt_nxt = w_cdt_nxt - w_need[CW-1:0];
    if (w_pop_ok)  w_cdt_nxt = w_cdt_nxt + CW'(1);
  end

  always_comb begin
    w_req_valid_nxt = r_req_valid;
    if (w_reserve)              w_req_valid_nxt = 1'b1;
    else if (mcif_rd_req_ready) w_req_valid_nxt = 1'b0;
  end

  // --------------------------------------------------------- response FIFO
  logic       w_push;
  logic       w_pop;
  logic [1:0] w_count_nxt;

  assign w_push = mcif_rd_rsp_valid && r_rsp_ready;
  assign w_pop  = (r_count != 2'd0) && bdma_rd_rsp_ready;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop)      w_count_nxt = r_count + 2'd1;
    else if (!w_push && w_pop) w_count_nxt = r_count - 2'd1;
  end

  // ------------------------------------------------------------ registers
  always_ff @(posedge autosa_core_clk) begin
    if (autosa_core_rst) begin
      r_req_valid    <= 1'b0;
      r_req_pd       <= '0;
      r_cdt_free     <= LP_MAXCW;
      r_idle         <= 1'b1;
      r_err_oversize <= 1'b0;
      r_err_cdt_ovf  <= 1'b0;
      r_rsp_ready    <= 1'b1;
      r_count        <= '0;
      r_wr_ptr       <= 1'b0;
      r_rd_ptr       <= 1'b0;
    end else begin
      r_req_valid <= w_req_valid_nxt;
      if (w_reserve) r_req_pd <= bdma_rd_req_pd;
      r_cdt_free  <= w_cdt_nxt;
      r_idle      <= !w_req_valid_nxt && (w_count_nxt == 2'd0) && (w_cdt_nxt == LP_MAXCW);
      if (w_accept && w_oversize) r_err_oversize <= 1'b1;
      if (w_cdt_ovf)              r_err_cdt_ovf  <= 1'b1;
      r_rsp_ready <= (w_count_nxt < 2'd2);
      r_count     <= w_count_nxt;
      if (w_push) r_wr_ptr <= !r_wr_ptr;
      if (w_pop)  r_rd_ptr <= !r_rd_ptr;
    end
  end

  // The beat storage holds data only and needs no reset.
  always_ff @(posedge autosa_core_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= mcif_rd_rsp_pd;
  end

  assign bdma_rd_req_ready = w_req_ready;
  assign mcif_rd_req_valid = r_req_valid;
  assign mcif_rd_req_pd    = r_req_pd;
  assign mcif_rd_rsp_ready = r_rsp_ready;
  assign bdma_rd_rsp_valid = (r_count != 2'd0);
  assign bdma_rd_rsp_pd    = r_mem[r_rd_ptr];
  assign cdt_free          = r_cdt_free;
  assign rd_idle           = r_idle;
  assign err_oversize      = r_err_oversize;
  assign err_cdt_ovf       = r_err_cdt_ovf;

`ifdef AUTOSA_BDMA_RDCLT_PERF_EN
  logic [31:0]   r_stall_cnt;
  logic [CW-1:0] r_hiwat;
  logic          w_stall;
  logic [CW-1:0] w_used;

  // Count only stalls caused by missing credits, not by a busy request slot.
  assign w_stall = bdma_rd_req_valid && !w_fits && !w_oversize;
  assign w_used  = LP_MAXCW - r_cdt_free;

  always_ff @(posedge autosa_core_clk) begin
    if (autosa_core_rst || perf_clr) begin
      r_stall_cnt <= '0;
      r_hiwat     <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_used > r_hiwat)               r_hiwat     <= w_used;
    end
  end

  assign perf_cdt_stall_cnt = r_stall_cnt;
  assign perf_cdt_hiwat     = r_hiwat;
`endif

endmodule

// File: tb/tb_autosa_bdma_rd_client.sv
module tb_autosa_bdma_rd_client;
  localparam int REQ_W = 79;
  localparam int RSP_W = 514;
  localparam int CW    = 9;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid, req_ready;
  logic [REQ_W-1:0] req_pd;
  logic             mreq_valid, mreq_ready;
  logic [REQ_W-1:0] mreq_pd;
  logic             mrsp_valid, mrsp_ready;
  logic [RSP_W-1:0] mrsp_pd;
  logic             brsp_valid, brsp_ready;
  logic [RSP_W-1:0] brsp_pd;
  logic             cdt_pop;
  logic [CW-1:0]    cdt_free;
  logic             rd_idle, err_oversize, err_cdt_ovf;

  int n_tests = 0;
  int n_fail  = 0;

  logic [REQ_W-1:0] exp_req_q [$];
  logic [RSP_W-1:0] exp_rsp_q [$];

  always #5 clk = ~clk;

  autosa_bdma_rd_client #(.REQ_W(REQ_W), .RSP_W(RSP_W), .CDT_MAX(256), .CW(CW)) dut (
    .autosa_core_clk  (clk),
    .autosa_core_rst  (rst),
    .bdma_rd_req_valid(req_valid),
    .bdma_rd_req_ready(req_ready),
    .bdma_rd_req_pd   (req_pd),
    .mcif_rd_req_valid(mreq_valid),
    .mcif_rd_req_ready(mreq_ready),
    .mcif_rd_req_pd   (mreq_pd),
    .mcif_rd_rsp_valid(mrsp_valid),
    .mcif_rd_rsp_ready(mrsp_ready),
    .mcif_rd_rsp_pd   (mrsp_pd),
    .bdma_rd_rsp_valid(brsp_valid),
    .bdma_rd_rsp_ready(brsp_ready),
    .bdma_rd_rsp_pd   (brsp_pd),
    .bdma_rd_cdt_pop  (cdt_pop),
    .cdt_free         (cdt_free),
    .rd_idle          (rd_idle),
    .err_oversize     (err_oversize),
    .err_cdt_ovf      (err_cdt_ovf)
  );

  function automatic logic [REQ_W-1:0] mk_req(input int unsigned size, input logic [63:0] addr);
    return {15'(size), addr};
  endfunction

  function automatic logic [RSP_W-1:0] mk_beat(input int unsigned k);
    logic [63:0] w;
    w = 64'h0123_4567_89AB_0000 + 64'(k);
    return {2'(k), {8{w}}};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor for the MCIF request port: pops expected request payloads in order.
  always @(negedge clk) begin
    if (rst === 1'b0 && mreq_valid && mreq_ready) begin
      n_tests++;
      if (exp_req_q.size() == 0) begin
        n_fail++;
        $display("FAIL mcif_req_unexpected: got pd %h expected none", mreq_pd);
      end else begin
        logic [REQ_W-1:0] e;
        e = exp_req_q.pop_front();
        if (mreq_pd !== e) begin
          n_fail++;
          $display("FAIL mcif_req_pd: got %h expected %h", mreq_pd, e);
        end
      end
    end
  end

  // Monitor for the BDMA response port: pops expected beats in arrival order.
  always @(negedge clk) begin
    if (rst === 1'b0 && brsp_valid && brsp_ready) begin
      n_tests++;
      if (exp_rsp_q.size() == 0) begin
        n_fail++;
        $display("FAIL bdma_rsp_unexpected: got %h expected none", brsp_pd);
      end else begin
        logic [RSP_W-1:0] e;
        e = exp_rsp_q.pop_front();
        if (brsp_pd !== e) begin
          n_fail++;
          $display("FAIL bdma_rsp_pd: got %h expected %h", brsp_pd, e);
        end
      end
    end
  end

  // Present one request and wait (bounded) until it is accepted.
  task automatic send_req(input int unsigned size, input logic [63:0] addr, input bit fwd);
    bit done;
    done = 0;
    req_pd    = mk_req(size, addr);
    req_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if (req_ready) begin
        if (fwd) exp_req_q.push_back(mk_req(size, addr));
        @(posedge clk);
        #1;
        done = 1;
      end else begin
        @(posedge clk);
      end
    end
    req_valid = 1'b0;
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL req_accept_timeout: got ready 0 expected 1 (size %0d)", size);
    end
  endtask

  task automatic pop_n(input int unsigned n);
    cdt_pop = 1'b1;
    for (int unsigned i = 0; i < n; i++) tick();
    cdt_pop = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    rst = 1'b1; req_valid = 0; req_pd = '0; mreq_ready = 1'b1;
    mrsp_valid = 0; mrsp_pd = '0; brsp_ready = 1'b1; cdt_pop = 0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_mreq_valid", 32'(mreq_valid), 0);
    check("rst_brsp_valid", 32'(brsp_valid), 0);
    check("rst_mrsp_ready", 32'(mrsp_ready), 1);
    check("rst_cdt_free",   32'(cdt_free), 256);
    check("rst_idle",       32'(rd_idle), 1);
    check("rst_errs",       32'({err_oversize, err_cdt_ovf}), 0);

    // Single request of 4 beats.
    send_req(3, 64'h0000_1000_0000_0040, 1);
    check("t1_mreq_valid", 32'(mreq_valid), 1);
    check("t1_cdt_252",    32'(cdt_free), 252);
    tick();
    pop_n(4);
    check("t1_cdt_256",  32'(cdt_free), 256);
    check("t1_idle",     32'(rd_idle), 1);

    // A 256-beat request drains all credits; a 1-beat request then waits for one pop.
    send_req(255, 64'h0000_0000_0000_2000, 1);
    check("t2_cdt_0", 32'(cdt_free), 0);
    req_pd = mk_req(0, 64'h0000_0000_0000_3000);
    req_valid = 1'b1;
    #1;
    check("t2_stall_a", 32'(req_ready), 0);
    tick();
    check("t2_stall_b", 32'(req_ready), 0);
    cdt_pop = 1'b1;
    #1;
    check("t2_stall_pop_cycle", 32'(req_ready), 0);
    tick();
    cdt_pop = 1'b0;
    #1;
    check("t2_ready_after_pop", 32'(req_ready), 1);
    exp_req_q.push_back(mk_req(0, 64'h0000_0000_0000_3000));
    tick();
    req_valid = 1'b0;
    check("t2_cdt_0b", 32'(cdt_free), 0);
    pop_n(256);
    check("t2_cdt_256", 32'(cdt_free), 256);
    check("t2_no_ovf",  32'(err_cdt_ovf), 0);

    // An oversize request (301 beats) is accepted, dropped and flagged.
    send_req(300, 64'h0000_0000_0000_4000, 0);
    check("t3_mreq_valid", 32'(mreq_valid), 0);
    check("t3_err_over",   32'(err_oversize), 1);
    check("t3_cdt_256",    32'(cdt_free), 256);

    // MCIF backpressure: the payload stays stable and the second request queues behind it.
    mreq_ready = 1'b0;
    send_req(0, 64'h0000_0000_0000_A000, 1);
    req_pd = mk_req(0, 64'h0000_0000_0000_B000);
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t4_pd_stable", 32'(mreq_pd == mk_req(0, 64'h0000_0000_0000_A000)), 1);
      check("t4_b_stall",   32'(req_ready), 0);
      tick();
    end
    mreq_ready = 1'b1;
    #1;
    check("t4_b_ready", 32'(req_ready), 1);
    exp_req_q.push_back(mk_req(0, 64'h0000_0000_0000_B000));
    tick();
    req_valid = 1'b0;
    check("t4_b_on_mcif", 32'(mreq_valid && mreq_pd == mk_req(0, 64'h0000_0000_0000_B000)), 1);
    check("t4_cdt_254", 32'(cdt_free), 254);
    tick();
    check("t4_mreq_drained", 32'(mreq_valid), 0);
    pop_n(2);

    // Three response beats with BDMA stalled: the FIFO fills after two and then drains in order.
    brsp_ready = 1'b0;
    for (int k = 1; k <= 3; k++) exp_rsp_q.push_back(mk_beat(k));
    mrsp_valid = 1'b1;
    mrsp_pd = mk_beat(1);
    tick();
    check("t5_brsp_valid", 32'(brsp_valid), 1);
    mrsp_pd = mk_beat(2);
    tick();
    mrsp_pd = mk_beat(3);
    #1;
    check("t5_full_ready", 32'(mrsp_ready), 0);
    tick(); tick();
    check("t5_full_hold",  32'(mrsp_ready), 0);
    brsp_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (mrsp_ready) got = 1;
      tick();
    end
    mrsp_valid = 1'b0;
    check("t5_third_pushed", 32'(got), 1);
    repeat (4) tick();
    check("t5_drained", 32'(brsp_valid), 0);
    check("t5_idle",    32'(rd_idle), 1);

    // Credit-pop overflow, then a reservation and a pop in the same cycle.
    cdt_pop = 1'b1;
    tick();
    cdt_pop = 1'b0;
    check("t6_err_ovf",  32'(err_cdt_ovf), 1);
    check("t6_cdt_256",  32'(cdt_free), 256);
    cdt_pop = 1'b1;
    send_req(3, 64'h0000_0000_0000_C000, 1);
    cdt_pop = 1'b0;
    check("t6_cdt_253", 32'(cdt_free), 253);
    tick();
    pop_n(3);
    check("t6_cdt_back", 32'(cdt_free), 256);
    check("t6_err_sticky", 32'({err_oversize, err_cdt_ovf}), 3);

    repeat (3) tick();
    check("end_req_q_empty", 32'(exp_req_q.size()), 0);
    check("end_rsp_q_empty", 32'(exp_rsp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
